// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: op encodings, FSM states and sw_* constants for the IMEM loader.
// The VFY states exist only when IMEM_LOADER_VERIFY_EN is defined.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_RUN   = 2'd2,
        OP_HALT  = 2'd3
    } op_e;

`ifdef IMEM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        HALT_IDLE, WR, RD_ADDR, RD_WAIT, VFY_ADDR, VFY_WAIT, RSP, RUN_IDLE
    } state_e;
`else
    typedef enum logic [2:0] {
        HALT_IDLE, WR, RD_ADDR, RD_WAIT, RSP, RUN_IDLE
    } state_e;
`endif

    localparam logic [31:0] SW_CMD_WRITE  = 32'd1;
    localparam logic [31:0] SW_RESET_HOLD = 32'd1;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: host command sequencer that halts the core, loads/reads IMEM and releases it.
// Define IMEM_LOADER_VERIFY_EN to read back every written word and flag mismatches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              sys_rstb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [31:0]       sw_reset,
    output logic [31:0]       sw_mem_addr,
    output logic [31:0]       sw_mem_wdata,
    output logic [31:0]       sw_mem_cmd,
    input  logic [31:0]       hw_mem_rdata
);

    state_e            state_q, state_d;
    logic              halt_q, halt_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] rdata;
    logic              idle, mem_op, reject;
    op_e               op;

    assign op     = op_e'(cmd_op);
    assign rdata  = DATA_W'(hw_mem_rdata);
    assign idle   = state_q == HALT_IDLE || state_q == RUN_IDLE;
    assign mem_op = op == OP_WRITE || op == OP_READ;
    // IMEM belongs to the running core, and the port only takes whole words.
    assign reject = mem_op && (state_q == RUN_IDLE || cmd_addr[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            HALT_IDLE, RUN_IDLE: begin
                if (cmd_valid && (reject || !mem_op)) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = reject;
                    halt_d      = op == OP_RUN ? 1'b0 : op == OP_HALT ? 1'b1 : halt_q;
                end else if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = op == OP_WRITE ? cmd_wdata : wdata_q;
                    wr_d    = op == OP_WRITE;
                    state_d = op == OP_WRITE ? WR : RD_ADDR;
                end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            WR:       state_d = VFY_ADDR;
            VFY_ADDR: state_d = VFY_WAIT;
            VFY_WAIT: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = rdata;
                rsp_err_d   = rdata != wdata_q;
            end
`else
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
            end
`endif
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = rdata;
                rsp_err_d   = 1'b0;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = halt_q ? HALT_IDLE : RUN_IDLE;
                end
            end
            default: state_d = HALT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rstb) begin
        if (!sys_rstb) begin
            state_q     <= HALT_IDLE;
            halt_q      <= 1'b1;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready    = idle;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign sw_reset     = halt_q ? SW_RESET_HOLD : 32'd0;
    assign sw_mem_addr  = 32'(addr_q);
    assign sw_mem_wdata = 32'(wdata_q);
    // Gate with reset so an in-flight strobe cannot reach the BRAM edge.
    assign sw_mem_cmd   = (wr_q && sys_rstb) ? SW_CMD_WRITE : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed test of imem_loader against a one-cycle BRAM model.
module tb_imem_loader;

`ifdef IMEM_LOADER_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam logic [1:0] OW = 2'd0, ORD = 2'd1, ORN = 2'd2, OH = 2'd3;
    localparam int WL = VFY ? 4 : 2;

    logic        clk, sys_rstb, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata, rsp_data, sw_reset, sw_mem_addr, sw_mem_wdata, sw_mem_cmd, hw_mem_rdata;
    logic [31:0] mem [128];
    logic [31:0] rdata_q, stuck_mask, s_addr, s_data;
    logic        mem_clr;
    int          strobe_cnt = 0;
    int          n_chk = 0, n_fail = 0;

    imem_loader dut (
        .clk(clk), .sys_rstb(sys_rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .sw_reset(sw_reset),
        .sw_mem_addr(sw_mem_addr), .sw_mem_wdata(sw_mem_wdata), .sw_mem_cmd(sw_mem_cmd),
        .hw_mem_rdata(hw_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
        end else if (sw_mem_cmd == 32'd1) begin
            mem[sw_mem_addr[8:2]] <= sw_mem_wdata;
        end
        rdata_q <= mem[sw_mem_addr[8:2]];
        if (sw_mem_cmd == 32'd1) begin
            strobe_cnt <= strobe_cnt + 1;
            s_addr     <= sw_mem_addr;
            s_data     <= sw_mem_wdata;
        end
    end
    assign hw_mem_rdata = rdata_q | stuck_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one command with rsp_ready high; returns response and cycles to rsp_valid.
    task automatic do_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [31:0] wd,
                          output logic err, output logic [31:0] data, output int strobes,
                          output int lat);
        int snap;
        snap      = strobe_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        err  = rsp_err;
        data = rsp_data;
        @(negedge clk);
        strobes = strobe_cnt - snap;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] data;
        int          strobes;
        int          lat;
        logic        rst;
    } vec_t;

    vec_t        v[16];
    logic        r_err;
    logic [31:0] r_data;
    int          r_str, r_lat;

    initial begin
        v[0]  = '{OW,  9'h010, 32'hE3A01005, 1'b0, VFY ? 32'hE3A01005 : 32'h0, 1, WL, 1'b1};
        v[1]  = '{ORD, 9'h010, 32'h0,        1'b0, 32'hE3A01005, 0, 3, 1'b1};
        v[2]  = '{OW,  9'h014, 32'h12345678, 1'b0, VFY ? 32'h12345678 : 32'h0, 1, WL, 1'b1};
        v[3]  = '{ORD, 9'h014, 32'h0,        1'b0, 32'h12345678, 0, 3, 1'b1};
        v[4]  = '{OW,  9'h002, 32'h5A5A5A5A, 1'b1, 32'h0, 0, 1, 1'b1};
        v[5]  = '{ORD, 9'h011, 32'h0,        1'b1, 32'h0, 0, 1, 1'b1};
        v[6]  = '{OH,  9'h000, 32'h0,        1'b0, 32'h0, 0, 1, 1'b1};
        v[7]  = '{ORN, 9'h000, 32'h0,        1'b0, 32'h0, 0, 1, 1'b0};
        v[8]  = '{OW,  9'h020, 32'hAAAA5555, 1'b1, 32'h0, 0, 1, 1'b0};
        v[9]  = '{ORD, 9'h010, 32'h0,        1'b1, 32'h0, 0, 1, 1'b0};
        v[10] = '{ORN, 9'h000, 32'h0,        1'b0, 32'h0, 0, 1, 1'b0};
        v[11] = '{OH,  9'h000, 32'h0,        1'b0, 32'h0, 0, 1, 1'b1};
        v[12] = '{ORD, 9'h020, 32'h0,        1'b0, 32'h0, 0, 3, 1'b1};
        v[13] = '{OW,  9'h1FC, 32'hFFFFFFFF, 1'b0, VFY ? 32'hFFFFFFFF : 32'h0, 1, WL, 1'b1};
        v[14] = '{ORD, 9'h1FC, 32'h0,        1'b0, 32'hFFFFFFFF, 0, 3, 1'b1};
        v[15] = '{ORD, 9'h010, 32'h0,        1'b0, 32'hE3A01005, 0, 3, 1'b1};

        sys_rstb = 1'b0; mem_clr = 1'b1; stuck_mask = 32'd0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        sys_rstb = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        chk("rst_sw_reset", sw_reset, 32'd1);
        chk("rst_sw_mem_cmd", sw_mem_cmd, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_sw_mem_addr", sw_mem_addr, 32'd0);
        chk("rst_sw_mem_wdata", sw_mem_wdata, 32'd0);

        for (int i = 0; i < 16; i++) begin
            do_cmd(v[i].op, v[i].addr, v[i].wd, r_err, r_data, r_str, r_lat);
            chk($sformatf("v%0d_err", i), 32'(r_err), 32'(v[i].err));
            chk($sformatf("v%0d_data", i), r_data, v[i].data);
            chk($sformatf("v%0d_strobes", i), 32'(r_str), 32'(v[i].strobes));
            chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(v[i].lat));
            chk($sformatf("v%0d_sw_reset", i), sw_reset, 32'(v[i].rst));
            chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
            chk($sformatf("v%0d_rsp_done", i), 32'(rsp_valid), 32'd0);
            if (v[i].strobes == 1) begin
                chk($sformatf("v%0d_strobe_addr", i), s_addr, 32'(v[i].addr));
                chk($sformatf("v%0d_strobe_data", i), s_data, v[i].wd);
            end
        end

        // Backpressure: response must stay frozen while the host stalls.
        cmd_valid = 1'b1; cmd_op = ORD; cmd_addr = 9'h014; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        r_lat = 1;
        while (!rsp_valid && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
        end
        chk("bp_latency", 32'(r_lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_data", k), rsp_data, 32'h12345678);
            chk($sformatf("bp%0d_err", k), 32'(rsp_err), 32'd0);
            chk($sformatf("bp%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_cmd_ready", 32'(cmd_ready), 32'd1);

        // Async reset during the WR cycle kills the strobe and the write.
        cmd_valid = 1'b1; cmd_op = OW; cmd_addr = 9'h030; cmd_wdata = 32'hDEADBEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_wr_strobe", sw_mem_cmd, 32'd1);
        #2 sys_rstb = 1'b0;
        #1;
        chk("mid_rst_sw_mem_cmd", sw_mem_cmd, 32'd0);
        chk("mid_rst_sw_reset", sw_reset, 32'd1);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", rsp_data, 32'd0);
        chk("mid_rst_sw_mem_addr", sw_mem_addr, 32'd0);
        chk("mid_rst_sw_mem_wdata", sw_mem_wdata, 32'd0);
        @(negedge clk);
        sys_rstb = 1'b1;
        @(negedge clk);
        do_cmd(ORD, 9'h030, 32'h0, r_err, r_data, r_str, r_lat);
        chk("aborted_write_data", r_data, 32'd0);
        chk("aborted_write_err", 32'(r_err), 32'd0);

`ifdef IMEM_LOADER_VERIFY_EN
        stuck_mask = 32'h0000_0100;
        do_cmd(OW, 9'h040, 32'h0000_0001, r_err, r_data, r_str, r_lat);
        chk("stuck_err", 32'(r_err), 32'd1);
        chk("stuck_data", r_data, 32'h0000_0101);
        chk("stuck_strobes", 32'(r_str), 32'd1);
        stuck_mask = 32'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
